// File: rtl/q_max_select.sv
// rtl/q_max_select.sv - Q-table row scan returning max_Q and an epsilon-greedy action
// Sequential argmax over a one-cycle-latency read port, with LFSR-driven exploration.
module q_max_select #(
  parameter int         N_STATES   = 37,
  parameter int         N_ACTIONS  = 4,
  parameter int         W          = 32,
  parameter logic [7:0] EPS_THRESH = 8'd26,
  parameter logic [7:0] LFSR_SEED  = 8'h01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [5:0]           maze_state,
  input  logic [N_ACTIONS-1:0] valid_mask,
  output logic                 q_rd_en,
  output logic [5:0]           q_rd_state,
  output logic [2:0]           q_rd_action,
  input  logic [W-1:0]         q_rd_data,
  output logic [W-1:0]         max_Q,
  output logic [2:0]           action,
  output logic                 greedy,
  output logic                 err,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, SCAN, LAST, DONE} state_t;

  state_t       state;
  logic [7:0]   lfsr;
  logic [7:0]   lfsr_nx;
  logic [7:0]   mask_r;
  logic [7:0]   mask_ext;
  logic [W-1:0] run_max;
  logic [2:0]   run_arg;
  logic         have_max;
  logic         rd_pend;
  logic [2:0]   rd_idx;
  logic         take;
  logic [W-1:0] nx_max;
  logic [2:0]   nx_arg;
  logic         nx_have;
  int           start_idx;
  int           idx;
  logic         exp_found;
  logic [2:0]   exp_act;
  logic         explore;
  logic [2:0]   final_act;

  assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_comb begin
    mask_ext = '0;
    mask_ext[N_ACTIONS-1:0] = valid_mask;
  end

  // rd_pend/rd_idx track which action the data on q_rd_data belongs to this cycle.
  always_comb begin
    take    = rd_pend && mask_r[rd_idx] &&
              (!have_max || ($signed(q_rd_data) > $signed(run_max)));
    nx_max  = take ? q_rd_data : run_max;
    nx_arg  = take ? rd_idx : run_arg;
    nx_have = have_max || take;
  end

  always_comb begin
    start_idx = int'(lfsr[1:0]) % N_ACTIONS;
    idx       = 0;
    exp_found = 1'b0;
    exp_act   = nx_arg;
    for (int i = 0; i < N_ACTIONS; i++) begin
      idx = (start_idx + i) % N_ACTIONS;
      if (!exp_found && mask_r[3'(idx)]) begin
        exp_found = 1'b1;
        exp_act   = 3'(idx);
      end
    end
    explore   = lfsr < EPS_THRESH;
    final_act = explore ? exp_act : nx_arg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      mask_r      <= '0;
      run_max     <= '0;
      run_arg     <= '0;
      have_max    <= 1'b0;
      rd_pend     <= 1'b0;
      rd_idx      <= '0;
      q_rd_en     <= 1'b0;
      q_rd_state  <= '0;
      q_rd_action <= '0;
      max_Q       <= '0;
      action      <= '0;
      greedy      <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= q_rd_en;
      rd_idx  <= q_rd_action;
      if (state == SCAN || state == LAST) begin
        run_max  <= nx_max;
        run_arg  <= nx_arg;
        have_max <= nx_have;
      end
      case (state)
        IDLE: begin
          if (start) begin
            lfsr       <= lfsr_nx;
            mask_r     <= mask_ext;
            q_rd_state <= maze_state;
            max_Q      <= '0;
            action     <= '0;
            greedy     <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
            have_max   <= 1'b0;
            if (int'(maze_state) >= N_STATES) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              q_rd_en     <= 1'b1;
              q_rd_action <= '0;
              state       <= SCAN;
            end
          end
        end
        SCAN: begin
          if (q_rd_action == 3'(N_ACTIONS - 1)) begin
            q_rd_en <= 1'b0;
            state   <= LAST;
          end else begin
            q_rd_action <= q_rd_action + 3'd1;
          end
        end
        LAST: begin
          // No legal action means nothing loaded: report zeros with err.
          max_Q  <= nx_have ? nx_max : '0;
          action <= nx_have ? final_act : 3'd0;
          greedy <= nx_have && (final_act == nx_arg);
          err    <= !nx_have;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_max_select.sv
// tb/tb_q_max_select.sv - directed bench for q_max_select (greedy and always-explore instances)
module tb_q_max_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  maze_state;
  logic [3:0]  valid_mask;

  logic        q_rd_en_g, greedy_g, err_g, busy_g, done_g;
  logic [5:0]  q_rd_state_g;
  logic [2:0]  q_rd_action_g, action_g;
  logic [31:0] q_rd_data_g, max_q_g;

  logic        q_rd_en_e, greedy_e, err_e, busy_e, done_e;
  logic [5:0]  q_rd_state_e;
  logic [2:0]  q_rd_action_e, action_e;
  logic [31:0] q_rd_data_e, max_q_e;

  logic [31:0] q_row [4];
  int tests = 0;
  int fails = 0;
  int lat, reads, n_done;

  q_max_select #(.EPS_THRESH(8'd0)) dut_g (
    .clk(clk), .rst(rst), .start(start), .maze_state(maze_state), .valid_mask(valid_mask),
    .q_rd_en(q_rd_en_g), .q_rd_state(q_rd_state_g), .q_rd_action(q_rd_action_g),
    .q_rd_data(q_rd_data_g), .max_Q(max_q_g), .action(action_g), .greedy(greedy_g),
    .err(err_g), .busy(busy_g), .done(done_g)
  );

  q_max_select #(.EPS_THRESH(8'd255), .LFSR_SEED(8'h01)) dut_e (
    .clk(clk), .rst(rst), .start(start), .maze_state(maze_state), .valid_mask(valid_mask),
    .q_rd_en(q_rd_en_e), .q_rd_state(q_rd_state_e), .q_rd_action(q_rd_action_e),
    .q_rd_data(q_rd_data_e), .max_Q(max_q_e), .action(action_e), .greedy(greedy_e),
    .err(err_e), .busy(busy_e), .done(done_e)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (q_rd_en_g) q_rd_data_g <= q_row[q_rd_action_g[1:0]];
    if (q_rd_en_e) q_rd_data_e <= q_row[q_rd_action_e[1:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [5:0] st, input logic [3:0] m);
    @(negedge clk);
    maze_state = st;
    valid_mask = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    reads = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (q_rd_en_g) reads++;
      if (done_g) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    maze_state = '0;
    valid_mask = '0;
    q_row[0] = '0; q_row[1] = '0; q_row[2] = '0; q_row[3] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_done", {31'd0, done_g}, 32'd0);
    check("reset_busy", {31'd0, busy_g}, 32'd0);
    check("reset_rd_en", {31'd0, q_rd_en_g}, 32'd0);
    check("reset_max", max_q_g, 32'd0);

    // Explore: LFSR 0x01 -> 0x02, start index 2 (illegal) -> action 3
    q_row[0] = 32'h0005_0000; q_row[1] = 32'h0001_0000; q_row[2] = 32'h0; q_row[3] = 32'h0002_0000;
    lookup(6'd3, 4'b1011);
    check("explore_done_e", {31'd0, done_e}, 32'd1);
    check("explore_action_e", {29'd0, action_e}, 32'd3);
    check("explore_greedy_e", {31'd0, greedy_e}, 32'd0);
    check("explore_max_e", max_q_e, 32'h0005_0000);
    check("explore_action_g", {29'd0, action_g}, 32'd0);
    check("explore_greedy_g", {31'd0, greedy_g}, 32'd1);

    // Greedy row {1.0, -2.0, 3.5, 0.25}
    q_row[0] = 32'h0001_0000; q_row[1] = 32'hFFFE_0000; q_row[2] = 32'h0003_8000; q_row[3] = 32'h0000_4000;
    lookup(6'd5, 4'b1111);
    check("greedy_latency", lat, 32'd6);
    check("greedy_reads", reads, 32'd4);
    check("greedy_max", max_q_g, 32'h0003_8000);
    check("greedy_action", {29'd0, action_g}, 32'd2);
    check("greedy_greedy", {31'd0, greedy_g}, 32'd1);
    check("greedy_err", {31'd0, err_g}, 32'd0);
    check("greedy_rd_state", {26'd0, q_rd_state_g}, 32'd5);
    // Explore instance: LFSR 0x02 -> 0x04, index 0 is legal but not argmax
    check("explore2_action_e", {29'd0, action_e}, 32'd0);
    check("explore2_greedy_e", {31'd0, greedy_e}, 32'd0);
    check("explore2_max_e", max_q_e, 32'h0003_8000);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done_g}, 32'd0);

    // Ties and negatives {-1, -1, -5, -3}
    q_row[0] = 32'hFFFF_0000; q_row[1] = 32'hFFFF_0000; q_row[2] = 32'hFFFB_0000; q_row[3] = 32'hFFFD_0000;
    lookup(6'd36, 4'b1111);
    check("tie_max", max_q_g, 32'hFFFF_0000);
    check("tie_action", {29'd0, action_g}, 32'd0);

    // Mask 0101 over {2, 9, 1, 9}
    q_row[0] = 32'h0002_0000; q_row[1] = 32'h0009_0000; q_row[2] = 32'h0001_0000; q_row[3] = 32'h0009_0000;
    lookup(6'd0, 4'b0101);
    check("mask_max", max_q_g, 32'h0002_0000);
    check("mask_action", {29'd0, action_g}, 32'd0);
    check("mask_err", {31'd0, err_g}, 32'd0);

    lookup(6'd1, 4'b0000);
    check("zmask_err", {31'd0, err_g}, 32'd1);
    check("zmask_max", max_q_g, 32'd0);
    check("zmask_action", {29'd0, action_g}, 32'd0);
    check("zmask_greedy", {31'd0, greedy_g}, 32'd0);
    check("zmask_reads", reads, 32'd4);

    lookup(6'd40, 4'b1111);
    check("range_latency", lat, 32'd1);
    check("range_reads", reads, 32'd0);
    check("range_err", {31'd0, err_g}, 32'd1);
    check("range_max", max_q_g, 32'd0);

    // Reset in the middle of a scan
    @(negedge clk);
    maze_state = 6'd2;
    valid_mask = 4'b1111;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_g) n_done++;
    end
    check("rst_no_done", n_done, 32'd0);
    check("rst_busy", {31'd0, busy_g}, 32'd0);
    check("rst_max", max_q_g, 32'd0);
    check("rst_err", {31'd0, err_g}, 32'd0);

    // start held through the busy window yields one done
    @(negedge clk);
    maze_state = 6'd4;
    start = 1'b1;
    n_done = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (done_g) n_done++;
      if (i == 6) start = 1'b0;
    end
    check("held_start_done", n_done, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/q_max_select.md
# q_max_select

Reads one state's row of the Q table and returns the row maximum `max_Q` plus the action to take, using epsilon-greedy selection with an internal LFSR. It is the read side of the Q-learning datapath: it drives the Q-table read port and feeds `max_Q` and `action` to the Q-update block. The scan of all actions is sequential over a one-cycle-latency read port, with a start/done handshake.

## Interface
- `N_STATES`, default 37: number of maze states.
- `N_ACTIONS`, default 4: actions per state, at most 8.
- `W`, default 32: Q word width, signed two's complement Q15.16.
- `EPS_THRESH`, default 8'd26: explore when LFSR < threshold (about 10%). A value of 0 disables exploration.
- `LFSR_SEED`, default 8'h01: LFSR reset value. Must be non-zero.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a lookup. Sampled only in IDLE.
- `maze_state`  in  6: state to look up. Latched when start is accepted.
- `valid_mask`  in  N_ACTIONS: legal actions (1 = legal). Latched when start is accepted.
- `q_rd_en`  out  1: Q-table read strobe.
- `q_rd_state`  out  6: read address, state.
- `q_rd_action`  out  3: read address, action.
- `q_rd_data`  in  W: read data. Valid the cycle after `q_rd_en`.
- `max_Q`  out  W: maximum Q over legal actions.
- `action`  out  3: selected action (greedy or explored).
- `greedy`  out  1: 1 when `action` is the argmax.
- `err`  out  1: 1 when `maze_state` is out of range or the mask is all zero.
- `busy`  out  1: high from the start edge until done.
- `done`  out  1: one-cycle pulse; outputs are valid from this cycle on.

## Operation
- FSM states: IDLE, SCAN, LAST, DONE.
- IDLE: when `start`=1, latch state and mask and advance the LFSR once.
  - LFSR update: next = {l[6:0], l[7]^l[5]^l[4]^l[3]}. The new value is the one used for this lookup.
  - Go to SCAN, or to DONE with `err`=1 if `maze_state` ≥ N_STATES. The out-of-range case issues no reads.
- SCAN, N_ACTIONS cycles: cycle k drives `q_rd_en`=1, `q_rd_state`=latched state, `q_rd_action`=k. Data returned for action k−1 is compared in the same cycle. Then go to LAST.
- LAST: compare the data for action N_ACTIONS−1, then go to DONE.
- Compare rule:
  - Signed comparison. Only legal actions participate.
  - The running max starts as "none", so the first legal action always loads.
  - Replace only on strictly greater, so ties go to the lowest index.
- Explore decision: explore when LFSR < EPS_THRESH (unsigned).
  - Explore action: the first legal action at or after index l[1:0] mod N_ACTIONS, rotating upward with wrap.
  - Otherwise `action` is the argmax.
  - `greedy`=1 when the chosen action equals the argmax, including the case where exploration lands on it.
- `max_Q` is always the legal maximum, regardless of exploration.
- All-zero mask: `max_Q`=0, `action`=0, `greedy`=0, `err`=1. Reads are still issued.
- DONE: assert `done` for one cycle, then return to IDLE.
- `max_Q`, `action`, `greedy` and `err` hold until the next accepted start, then clear to 0 at that start edge.
- `start` while busy is ignored, with no queuing.

## Timing
- Start is sampled at edge T.
- SCAN occupies cycles T+1 … T+N_ACTIONS.
- LAST is cycle T+N_ACTIONS+1.
- `done`=1 during cycle T+N_ACTIONS+2, which is cycle 6 with defaults.
- Out-of-range state: `done` during cycle T+1.
- Next start is accepted at the earliest at the edge ending the DONE cycle+1, i.e. when back in IDLE.
- Reset:
  - All outputs go to 0, the FSM goes to IDLE, and the LFSR loads LFSR_SEED.
  - Reset mid-scan aborts the scan with no `done` pulse.
  - `rst` takes priority over `start` in the same cycle.
- `q_rd_en` is never high outside SCAN.

## Test plan
- Greedy: EPS_THRESH=0, mask 1111, row {1.0, −2.0, 3.5, 0.25} (0x00010000, 0xFFFE0000, 0x00038000, 0x00004000) → `max_Q`=0x00038000, `action`=2, `greedy`=1, `done` at T+6.
- Tie and negatives: row {−1, −1, −5, −3} in Q15.16, mask 1111 → `max_Q`=0xFFFF0000, `action`=0.
- Mask: mask 0101, row {2, 9, 1, 9} → `max_Q`=2.0, `action`=0. Mask 0000 → `err`=1, `max_Q`=0, `action`=0.
- Explore: seed 0x01, EPS_THRESH=255, mask 1011, row {5, 1, 0, 2}. The LFSR becomes 0x02, giving start index 2 and selection 3 → `action`=3, `greedy`=0, `max_Q`=5.0.
- Range, reset and handshake:
  - `maze_state`=40 → `err`=1 at T+1, no `q_rd_en`.
  - `rst` during SCAN → no `done`, outputs 0.
  - `start` held high during busy → exactly one `done`.
